led_switch_puzzle: RTL

Parametrised successor to the board-level LED/switch puzzle: a multi-round "match the lights" module for the KTNE bomb. Each round it shows a pseudo-random target pattern on the red LEDs. The player sets the switches to the mode-dependent answer and presses the submit button. Correct answers advance a green-LED progress bar; wrong answers raise a strike. The block sits below the board wrapper and drives the strike/solved lines to the bomb controller.

---
 rtl/ktne_pkg.sv | 31 +++
 rtl/button_debounce.sv | 42 ++++
 rtl/led_switch_puzzle.sv | 122 ++++++++++++
 3 files changed

// File: rtl/ktne_pkg.sv
// Shared types and helpers for the KTNE puzzle modules.
package ktne_pkg;

    typedef enum logic [2:0] {
        LOAD,
        SHOW,
        CHECK,
        SOLVED,
        FAILED
    } state_t;

    localparam int MODE_DIRECT  = 0;
    localparam int MODE_INVERT  = 1;
    localparam int MODE_REVERSE = 2;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // Progress bar with the lowest n bits lit.
    function automatic logic [7:0] thermometer(input logic [3:0] n);
        logic [7:0] t;
        t = '0;
        for (int i = 0; i < 8; i++) t[i] = (4'(i) < n);
        return t;
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for a raw button.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          level_q;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            sync    <= {sync[0], btn};
            level_q <= level;
            press   <= level & ~level_q;
            // Any agreement restarts the count; the level flips only after an unbroken run.
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_switch_puzzle.sv
// Multi-round "match the lights" puzzle: shows LFSR targets, checks switch answers, tracks strikes.
module led_switch_puzzle
    import ktne_pkg::*;
#(
    parameter int          N_SW            = 18,
    parameter int          ROUNDS          = 3,
    parameter int          MAX_STRIKES     = 3,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          MODE            = 0,
    parameter logic [31:0] SEED            = 32'hACE1_0001
) (
    input  logic                               CLOCK_50,
    input  logic                               reset,
    input  logic                               submit,
    input  logic [N_SW-1:0]                    sw,
    output logic [N_SW-1:0]                    ledr,
    output logic [7:0]                         ledg,
    output logic                               strike,
    output logic [$clog2(MAX_STRIKES+1)-1:0]   strikes,
    output logic                               solved,
    output logic                               failed
);

    localparam int RW  = $clog2(ROUNDS + 1);
    localparam int SKW = $clog2(MAX_STRIKES + 1);

    state_t          state;
    logic [31:0]     lfsr;
    logic [N_SW-1:0] target;
    logic [N_SW-1:0] answer;
    logic [N_SW-1:0] sw_meta;
    logic [N_SW-1:0] sw_sync;
    logic [RW-1:0]   round;
    logic [RW-1:0]   round_inc;
    logic [SKW-1:0]  strikes_inc;
    logic            press;
    logic            submit_level;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_submit (
        .clk   (CLOCK_50),
        .reset (reset),
        .btn   (submit),
        .level (submit_level),
        .press (press)
    );

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        answer = target;
        case (MODE)
            MODE_INVERT:  answer = ~target;
            MODE_REVERSE: for (int i = 0; i < N_SW; i++) answer[i] = target[N_SW-1-i];
            default:      answer = target;
        endcase
    end

    assign round_inc   = round + 1'b1;
    assign strikes_inc = strikes + 1'b1;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= LOAD;
            lfsr    <= SEED;
            target  <= '0;
            round   <= '0;
            strikes <= '0;
            ledr    <= '0;
            ledg    <= '0;
            strike  <= 1'b0;
            solved  <= 1'b0;
            failed  <= 1'b0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= sw;
            sw_sync <= sw_meta;
            strike  <= 1'b0;
            case (state)
                LOAD: begin
                    target <= lfsr[N_SW-1:0];
                    ledr   <= lfsr[N_SW-1:0];
                    lfsr   <= lfsr_step(lfsr);
                    state  <= SHOW;
                end
                SHOW: begin
                    if (press) state <= CHECK;
                end
                CHECK: begin
                    if (sw_sync == answer) begin
                        round <= round_inc;
                        if (round_inc == RW'(ROUNDS)) begin
                            state  <= SOLVED;
                            ledg   <= 8'hFF;
                            ledr   <= '0;
                            solved <= 1'b1;
                        end else begin
                            ledg  <= thermometer(4'(round_inc));
                            state <= LOAD;
                        end
                    end else begin
                        // A wrong answer keeps the same target on display.
                        strike  <= 1'b1;
                        strikes <= strikes_inc;
                        if (strikes_inc == SKW'(MAX_STRIKES)) begin
                            state  <= FAILED;
                            ledr   <= '1;
                            ledg   <= '0;
                            failed <= 1'b1;
                        end else begin
                            state <= SHOW;
                        end
                    end
                end
                SOLVED, FAILED: state <= state;
                default:        state <= LOAD;
            endcase
        end
    end

endmodule
